// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - borrow_in), one bit per clock, LSB first.
// Define SERIAL_ADD_MODE_EN to add a 'mode' input that turns the cell into a full adder.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; diff/borrow_out hold the last result
// S_SHIFT | one operand bit per edge through the full-subtractor cell
// S_DONE  | result registered, done high for this single cycle
module serial_subtractor #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
`ifdef SERIAL_ADD_MODE_EN
   input  logic             mode,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_diff_sr;
   logic             r_brw;
   logic [CW-1:0]    r_count;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow_out;

   logic             w_mode;
   logic             w_a0;
   logic             w_b0;
   logic             w_d;
   logic             w_brw_next;
   logic [WIDTH:0]   w_diff_cat;
   logic [WIDTH-1:0] w_diff_shift;

`ifdef SERIAL_ADD_MODE_EN
   logic r_mode;
   assign w_mode = r_mode;
`else
   assign w_mode = 1'b0;
`endif

   assign w_a0 = r_a_sr[0];
   assign w_b0 = r_b_sr[0];
   assign w_d  = w_a0 ^ w_b0 ^ r_brw;
   // r_brw doubles as carry when the adder mode is selected
   assign w_brw_next = w_mode ? ((w_a0 & w_b0) | (r_brw & (w_a0 ^ w_b0)))
                              : ((~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_brw));

   // Concatenate-then-slice so WIDTH=1 needs no special case
   assign w_diff_cat   = {w_d, r_diff_sr};
   assign w_diff_shift = w_diff_cat[WIDTH:1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_a_sr       <= '0;
         r_b_sr       <= '0;
         r_diff_sr    <= '0;
         r_brw        <= 1'b0;
         r_count      <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_diff       <= '0;
         r_borrow_out <= 1'b0;
`ifdef SERIAL_ADD_MODE_EN
         r_mode       <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a_sr    <= a;
                  r_b_sr    <= b;
                  r_brw     <= borrow_in;
                  r_diff_sr <= '0;
                  r_count   <= '0;
                  r_busy    <= 1'b1;
`ifdef SERIAL_ADD_MODE_EN
                  r_mode    <= mode;
`endif
                  r_state   <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_a_sr    <= r_a_sr >> 1;
               r_b_sr    <= r_b_sr >> 1;
               r_diff_sr <= w_diff_shift;
               r_brw     <= w_brw_next;
               r_count   <= r_count + CW'(1);
               // Final bit: publish the result so done lines up with the DONE cycle
               if (r_count == LAST) begin
                  r_diff       <= w_diff_shift;
                  r_borrow_out <= w_brw_next;
                  r_done       <= 1'b1;
                  r_state      <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign diff       = r_diff;
   assign borrow_out = r_borrow_out;

endmodule
